// File: rtl/shifter_pkg.sv
// shifter_pkg: shared definitions for the pipelined barrel shifter.
//   op_t        - 2-bit operation code (SLL, SRL, SRA, ROR)
//   stage_shift - shift distance applied by pipeline stage k (2^k)
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  function automatic int unsigned stage_shift(input int unsigned k);
    return 32'd1 << k;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// shift_stage: one registered stage of the barrel shifter. It shifts the
// incoming payload by 2^K when amt[K] is set and updates the carry. The
// payload and valid bit are then held in a register that follows the
// pipeline load rule.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   load_i         stage may load (it is empty or the downstream stage loads)
//   up_*_i         payload and valid bit from the upstream stage
//   valid_o, *_o   registered payload of this stage
//   nxt_data_o     combinational shifted data (the value about to be loaded)
module shift_stage
  import shifter_pkg::*;
#(
  parameter  int unsigned W  = 8,
  parameter  int unsigned K  = 0,
  localparam int unsigned SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          up_valid_i,
  input  logic [W-1:0]  up_data_i,
  input  logic [SW-1:0] up_amt_i,
  input  op_t           up_op_i,
  input  logic          up_sign_i,
  input  logic          up_carry_i,
  output logic          valid_o,
  output logic [W-1:0]  data_o,
  output logic [SW-1:0] amt_o,
  output op_t           op_o,
  output logic          sign_o,
  output logic          carry_o,
  output logic [W-1:0]  nxt_data_o
);

  localparam int unsigned S = stage_shift(K);

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] amt;
    op_t           op;
    logic          sign;
    logic          carry;
  } payload_t;

  payload_t payload_q, payload_d;
  logic     valid_q;

  logic [2*W-1:0] ext_sra;
  logic [2*W-1:0] ext_ror;
  logic [W-1:0]   sh_data;
  logic           sh_carry;

  // Sign-extended and doubled copies let SRA and ROR be taken as one slice.
  assign ext_sra = {{W{up_sign_i}}, up_data_i};
  assign ext_ror = {up_data_i, up_data_i};

  always_comb begin
    sh_data  = up_data_i;
    sh_carry = up_carry_i;
    if (up_amt_i[K]) begin
      case (up_op_i)
        OP_SLL: begin
          sh_data  = up_data_i << S;
          sh_carry = up_data_i[W-S];
        end
        OP_SRL: begin
          sh_data  = up_data_i >> S;
          sh_carry = up_data_i[S-1];
        end
        OP_SRA: begin
          sh_data  = ext_sra[S +: W];
          sh_carry = up_data_i[S-1];
        end
        OP_ROR: begin
          // The bit that lands in position W-1 is d[S-1].
          sh_data  = ext_ror[S +: W];
          sh_carry = up_data_i[S-1];
        end
      endcase
    end
  end

  always_comb begin
    payload_d       = '0;
    payload_d.data  = sh_data;
    payload_d.amt   = up_amt_i;
    payload_d.op    = up_op_i;
    payload_d.sign  = up_sign_i;
    payload_d.carry = sh_carry;
  end

  // The payload only changes on a real capture, so a bubble moving in
  // leaves the last result in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else if (load_i) begin
      valid_q <= up_valid_i;
      if (up_valid_i) begin
        payload_q <= payload_d;
      end
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = payload_q.data;
  assign amt_o      = payload_q.amt;
  assign op_o       = payload_q.op;
  assign sign_o     = payload_q.sign;
  assign carry_o    = payload_q.carry;
  assign nxt_data_o = sh_data;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: a W-bit shifter with SLL/SRL/SRA/ROR, built from
// one registered stage per shift-amount bit and a valid/ready handshake on
// both sides. Throughput is one op per cycle and latency is SW cycles.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready                 input handshake
//   in_data, in_amt, in_op            operand, shift amount, operation
//   out_valid/out_ready               output handshake
//   out_data, out_carry, out_zero     result, last bit shifted out, zero flag
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int unsigned W  = 8,
  localparam int unsigned SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [SW-1:0] in_amt,
  input  logic [1:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_carry,
  output logic          out_zero
);

  // Index 0 is the pipeline input, index k+1 is the output of stage k.
  logic          v     [SW+1];
  logic [W-1:0]  data  [SW+1];
  logic [SW-1:0] amt   [SW+1];
  op_t           op    [SW+1];
  logic          sign  [SW+1];
  logic          carry [SW+1];
  logic [W-1:0]  nxt   [SW];
  logic [SW-1:0] ld;
  logic          zero_q;

  assign v[0]     = in_valid;
  assign data[0]  = in_data;
  assign amt[0]   = in_amt;
  assign op[0]    = op_t'(in_op);
  assign sign[0]  = in_data[W-1];
  assign carry[0] = 1'b0;

  // Ready chain, evaluated from the output back towards the input: a stage
  // loads when it is empty or its successor loads this cycle.
  always_comb begin
    ld       = '0;
    ld[SW-1] = !v[SW] || out_ready;
    for (int unsigned j = 1; j < SW; j++) begin
      ld[SW-1-j] = !v[SW-j] || ld[SW-j];
    end
  end

  for (genvar k = 0; k < SW; k++) begin : g_stage
    shift_stage #(
      .W (W),
      .K (k)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ld[k]),
      .up_valid_i (v[k]),
      .up_data_i  (data[k]),
      .up_amt_i   (amt[k]),
      .up_op_i    (op[k]),
      .up_sign_i  (sign[k]),
      .up_carry_i (carry[k]),
      .valid_o    (v[k+1]),
      .data_o     (data[k+1]),
      .amt_o      (amt[k+1]),
      .op_o       (op[k+1]),
      .sign_o     (sign[k+1]),
      .carry_o    (carry[k+1]),
      .nxt_data_o (nxt[k])
    );
  end

  // Zero flag is taken from the data entering the last stage so it is
  // registered alongside out_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (ld[SW-1] && v[SW-1]) begin
      zero_q <= (nxt[SW-1] == '0);
    end
  end

  assign in_ready  = ld[0] && !rst;
  assign out_valid = v[SW];
  assign out_data  = data[SW];
  assign out_carry = carry[SW];
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter at W=8 plus a random run at
// W=32, checked against a bit-level reference function.
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_carry8, out_zero8;
  logic [7:0] in_data8, out_data8;
  logic [2:0] in_amt8;
  logic [1:0] in_op8;

  logic        in_valid32, in_ready32, out_valid32, out_ready32, out_carry32, out_zero32;
  logic [31:0] in_data32, out_data32;
  logic [4:0]  in_amt32;
  logic [1:0]  in_op32;

  int n_cmp = 0;
  int n_err = 0;

  pipelined_barrel_shifter #(.W(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_data   (in_data8),
    .in_amt    (in_amt8),
    .in_op     (in_op8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_data  (out_data8),
    .out_carry (out_carry8),
    .out_zero  (out_zero8)
  );

  pipelined_barrel_shifter #(.W(32)) u_dut32 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .in_data   (in_data32),
    .in_amt    (in_amt32),
    .in_op     (in_op32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .out_data  (out_data32),
    .out_carry (out_carry32),
    .out_zero  (out_zero32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Returns {carry, data} for a w-bit operand.
  function automatic logic [32:0] ref_fn(input int unsigned w, input logic [31:0] d_in,
                                         input int unsigned n, input logic [1:0] opc);
    logic [31:0] mask, d, r;
    logic c;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    d = d_in & mask;
    r = '0;
    c = 1'b0;
    case (opc)
      2'b00: begin r = (d << n) & mask; if (n != 0) c = d[w-n]; end
      2'b01: begin r = d >> n; if (n != 0) c = d[n-1]; end
      2'b10: begin
        r = d >> n;
        if (d[w-1]) r = r | (mask & ~(mask >> n));
        if (n != 0) c = d[n-1];
      end
      default: begin r = ((d >> n) | (d << (w - n))) & mask; if (n != 0) c = r[w-1]; end
    endcase
    return {c, r};
  endfunction

  // Issue one op to the 8-bit DUT and wait (bounded) for its result.
  task automatic issue8(input logic [7:0] d, input logic [2:0] a, input logic [1:0] o,
                        output int lat);
    in_valid8 = 1'b1;
    in_data8  = d;
    in_amt8   = a;
    in_op8    = o;
    step;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 10) begin
      step;
      lat++;
    end
  endtask

  initial begin
    logic [32:0] e;
    logic [32:0] bp_e [6];
    int lat;
    logic [7:0]  vd [16];
    logic [2:0]  va [16];
    logic [1:0]  vo [16];
    logic [31:0] wd [16];
    logic [4:0]  wa [16];
    logic [1:0]  wo [16];
    logic [7:0]  dir_d [4];
    logic        dir_c [4];
    logic [7:0]  bp_d [6];
    bit          exp_v;
    int          idx;

    dir_d = '{8'h40, 8'h05, 8'hFD, 8'h95};
    dir_c = '{1'b0, 1'b1, 1'b1, 1'b1};
    bp_d  = '{8'h96, 8'h5A, 8'hC3, 8'h81, 8'h7E, 8'h24};

    rst = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0; in_amt8 = '0; in_op8 = '0; out_ready8 = 1'b1;
    in_valid32 = 1'b0; in_data32 = '0; in_amt32 = '0; in_op32 = '0; out_ready32 = 1'b1;
    step;
    step;
    rst = 1'b0;
    #1;
    chk("reset out_valid", out_valid8, 0);
    chk("reset out_data", out_data8, 0);
    chk("reset out_carry", out_carry8, 0);
    chk("reset out_zero", out_zero8, 0);
    chk("reset in_ready", in_ready8, 1);
    chk("reset32 out_valid", out_valid32, 0);
    chk("reset32 in_ready", in_ready32, 1);

    // Directed: 10110010 by 5 for each op.
    for (int i = 0; i < 4; i++) begin
      issue8(8'hB2, 3'd5, 2'(i), lat);
      chk("dir latency", lat, 3);
      chk("dir data", out_data8, dir_d[i]);
      chk("dir carry", out_carry8, dir_c[i]);
      chk("dir zero", out_zero8, 0);
    end

    // Amount 0 passes data unchanged with carry 0.
    for (int i = 0; i < 4; i++) begin
      issue8(8'hA5, 3'd0, 2'(i), lat);
      chk("amt0 latency", lat, 3);
      chk("amt0 data", out_data8, 8'hA5);
      chk("amt0 carry", out_carry8, 0);
    end

    issue8(8'h01, 3'd7, 2'b00, lat);
    chk("sll7 data", out_data8, 8'h80);
    chk("sll7 zero", out_zero8, 0);
    chk("sll7 carry", out_carry8, 0);

    issue8(8'h7F, 3'd7, 2'b01, lat);
    chk("srl7 data", out_data8, 8'h00);
    chk("srl7 zero", out_zero8, 1);
    chk("srl7 carry", out_carry8, 1);

    // Back-to-back random ops, W=8.
    for (int i = 0; i < 16; i++) begin
      vd[i] = 8'($urandom);
      va[i] = 3'($urandom_range(0, 7));
      vo[i] = 2'($urandom_range(0, 3));
    end
    for (int s = 0; s < 16 + 3; s++) begin
      if (s < 16) begin
        in_valid8 = 1'b1; in_data8 = vd[s]; in_amt8 = va[s]; in_op8 = vo[s];
        #1;
        chk("b2b in_ready", in_ready8, 1);
      end else begin
        in_valid8 = 1'b0;
      end
      step;
      exp_v = (s + 1 >= 3) && (s + 1 - 3 < 16);
      chk("b2b out_valid", out_valid8, exp_v);
      if (exp_v) begin
        idx = s + 1 - 3;
        e = ref_fn(8, {24'd0, vd[idx]}, va[idx], vo[idx]);
        chk("b2b data", out_data8, e[7:0]);
        chk("b2b carry", out_carry8, e[32]);
        chk("b2b zero", out_zero8, e[7:0] == 8'h00);
      end
    end

    // Backpressure: consumer stalls for 6 cycles while the producer pushes.
    for (int i = 0; i < 6; i++) begin
      bp_e[i] = ref_fn(8, {24'd0, bp_d[i]}, (i % 7) + 1, i % 4);
    end
    for (int i = 0; i < 6; i++) begin
      out_ready8 = 1'b0;
      in_valid8 = 1'b1; in_data8 = bp_d[i]; in_amt8 = 3'((i % 7) + 1); in_op8 = 2'(i % 4);
      #1;
      chk("bp in_ready", in_ready8, i < 3);
      step;
      chk("bp out_valid", out_valid8, i >= 2);
      if (i >= 2) begin
        chk("bp hold data", out_data8, bp_e[0][7:0]);
        chk("bp hold carry", out_carry8, bp_e[0][32]);
      end
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("drain valid", out_valid8, 1);
      chk("drain data", out_data8, bp_e[j][7:0]);
      chk("drain carry", out_carry8, bp_e[j][32]);
      step;
    end
    chk("drain empty", out_valid8, 0);

    // Reset with two ops in flight.
    in_valid8 = 1'b1; in_data8 = 8'h3C; in_amt8 = 3'd2; in_op8 = 2'b00;
    step;
    in_data8 = 8'hF0; in_amt8 = 3'd1; in_op8 = 2'b01;
    step;
    rst = 1'b1;
    in_data8 = 8'h55; in_amt8 = 3'd3; in_op8 = 2'b11;
    step;
    rst = 1'b0;
    in_valid8 = 1'b0;
    #1;
    chk("midrst out_valid", out_valid8, 0);
    chk("midrst out_data", out_data8, 0);
    chk("midrst out_carry", out_carry8, 0);
    chk("midrst out_zero", out_zero8, 0);
    chk("midrst in_ready", in_ready8, 1);
    for (int j = 0; j < 5; j++) begin
      step;
      chk("midrst no output", out_valid8, 0);
    end
    issue8(8'h81, 3'd1, 2'b11, lat);
    chk("post-rst latency", lat, 3);
    chk("post-rst data", out_data8, 8'hC0);
    chk("post-rst carry", out_carry8, 1);
    step;

    // Back-to-back random ops, W=32.
    for (int i = 0; i < 16; i++) begin
      wd[i] = $urandom;
      wa[i] = 5'($urandom_range(0, 31));
      wo[i] = 2'($urandom_range(0, 3));
    end
    wd[3] = 32'h8000_0001;
    wa[3] = 5'd31;
    wo[3] = 2'b10;
    for (int s = 0; s < 16 + 5; s++) begin
      if (s < 16) begin
        in_valid32 = 1'b1; in_data32 = wd[s]; in_amt32 = wa[s]; in_op32 = wo[s];
        #1;
        chk("w32 in_ready", in_ready32, 1);
      end else begin
        in_valid32 = 1'b0;
      end
      step;
      exp_v = (s + 1 >= 5) && (s + 1 - 5 < 16);
      chk("w32 out_valid", out_valid32, exp_v);
      if (exp_v) begin
        idx = s + 1 - 5;
        e = ref_fn(32, wd[idx], wa[idx], wo[idx]);
        chk("w32 data", out_data32, e[31:0]);
        chk("w32 carry", out_carry32, e[32]);
        chk("w32 zero", out_zero32, e[31:0] == 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
